// File: rtl/ram_access_master.sv
// Load/store initiator for the word-addressed data RAM.
// Sub-word stores use read-modify-write; loads extract and extend the addressed lane.
module ram_access_master #(
   parameter int RAM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        misaligned_o,
   output logic        oob_o,
   output logic        ram_wr_en_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

   localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

   state_t      state_reg;
   logic        we_q;
   logic [1:0]  size_q;
   logic        unsigned_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        done_reg;
   logic        mis_reg;
   logic        oob_reg;
   logic        wr_en_reg;
   logic [31:0] rdata_reg;
   logic [31:0] wr_data_reg;

   logic        mis_next;
   logic        oob_next;
   logic [3:0]  be_next;
   logic [31:0] wide_wdata;
   logic [31:0] merged_word;
   logic [31:0] lane_word;
   logic [31:0] load_data;

   // Request checks are evaluated on the incoming request so errors resolve at accept.
   always_comb begin
      mis_next = 1'b0;
      case (size_i)
         2'b00:   mis_next = 1'b0;
         2'b01:   mis_next = addr_i[0];
         2'b10:   mis_next = |addr_i[1:0];
         default: mis_next = 1'b1;
      endcase
   end

   assign oob_next = ({2'b00, addr_i[31:2]} >= RAM_LIMIT);

   always_comb begin
      be_next    = 4'b1111;
      wide_wdata = wdata_q;
      case (size_q)
         2'b00: begin
            be_next    = 4'b0001 << addr_q[1:0];
            wide_wdata = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_next    = addr_q[1] ? 4'b1100 : 4'b0011;
            wide_wdata = {2{wdata_q[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wide_wdata = wdata_q;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_merge
         assign merged_word[8*gi +: 8] = be_next[gi] ? wide_wdata[8*gi +: 8]
                                                     : ram_data_i[8*gi +: 8];
      end
   endgenerate

   assign lane_word = ram_data_i >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_data = ram_data_i;
      case (size_q)
         2'b00:   load_data = unsigned_q ? {24'd0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
         2'b01:   load_data = unsigned_q ? {16'd0, lane_word[15:0]}
                                         : {{16{lane_word[15]}}, lane_word[15:0]};
         default: load_data = ram_data_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         unsigned_q  <= 1'b0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         done_reg    <= 1'b0;
         mis_reg     <= 1'b0;
         oob_reg     <= 1'b0;
         wr_en_reg   <= 1'b0;
         rdata_reg   <= 32'd0;
         wr_data_reg <= 32'd0;
      end else begin
         done_reg  <= 1'b0;
         wr_en_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_i) begin
                  we_q       <= we_i;
                  size_q     <= size_i;
                  unsigned_q <= unsigned_i;
                  addr_q     <= addr_i;
                  wdata_q    <= wdata_i;
                  mis_reg    <= mis_next;
                  oob_reg    <= oob_next;
                  if (mis_next || oob_next) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else if (we_i && size_i == 2'b10) begin
                     state_reg   <= WRITE;
                     wr_en_reg   <= 1'b1;
                     wr_data_reg <= wdata_i;
                  end else begin
                     state_reg <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (we_q) begin
                  state_reg   <= WRITE;
                  wr_en_reg   <= 1'b1;
                  wr_data_reg <= merged_word;
               end else begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  rdata_reg <= load_data;
               end
            end
            WRITE: begin
               state_reg <= DONE;
               done_reg  <= 1'b1;
            end
            default: begin
               state_reg <= IDLE;
               mis_reg   <= 1'b0;
               oob_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o       = (state_reg != IDLE);
   assign done_o       = done_reg;
   assign rdata_o      = rdata_reg;
   assign misaligned_o = mis_reg;
   assign oob_o        = oob_reg;
   assign ram_wr_en_o  = wr_en_reg;
   assign ram_addr_o   = {addr_q[31:2], 2'b00};
   assign ram_data_o   = wr_data_reg;

endmodule

// File: tb/tb_ram_access_master.sv
// Directed bench for ram_access_master with a behavioural RAM attached.
module tb_ram_access_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        misaligned_o;
   logic        oob_o;
   logic        ram_wr_en_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;

   logic [31:0] mem [4096];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ram_access_master #(.RAM_WORDS(4096)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
      .misaligned_o(misaligned_o), .oob_o(oob_o), .ram_wr_en_o(ram_wr_en_o),
      .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
   );

   assign ram_data_i = mem[ram_addr_o[13:2]];

   always @(posedge clk) begin
      if (ram_wr_en_o) mem[ram_addr_o[13:2]] <= ram_data_o;
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        mis;
      logic        oob;
      logic [11:0] widx;
      logic [31:0] word;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                               logic [31:0] wdata, int lat, logic [31:0] rdata,
                               logic mis, logic oob, logic [11:0] widx, logic [31:0] word);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.lat = lat; v.rdata = rdata; v.mis = mis; v.oob = oob; v.widx = widx; v.word = word;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int lat;
      int wr_cnt;
      bit seen;
      @(negedge clk);
      req_i = 1'b1; we_i = v.we; size_i = v.size; unsigned_i = v.uns;
      addr_i = v.addr; wdata_i = v.wdata;
      lat = 0; wr_cnt = 0; seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         req_i = 1'b0;
         lat++;
         if (ram_wr_en_o) wr_cnt++;
         if (done_o) seen = 1'b1;
      end
      if (!seen) lat = 99;
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d rdata", idx), rdata_o, v.rdata);
      chk($sformatf("v%0d misaligned", idx), {31'd0, misaligned_o}, {31'd0, v.mis});
      chk($sformatf("v%0d oob", idx), {31'd0, oob_o}, {31'd0, v.oob});
      chk($sformatf("v%0d wr_pulses", idx), 32'(wr_cnt),
          (v.we && !v.mis && !v.oob) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d ram_word", idx), mem[v.widx], v.word);
      $display("vec %0d we=%0d size=%0d addr=%08h lat=%0d rdata=%08h mis=%0d oob=%0d",
               idx, v.we, v.size, v.addr, lat, rdata_o, v.mis, v.oob);
   endtask

   initial begin
      logic [31:0] exp_rd [4];
      int done_cnt;
      for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
      rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
      addr_i = 32'd0; wdata_i = 32'd0;

      //            we  sz    u   addr          wdata         lat rdata         mis  oob  widx    word
      tbl[0]  = mk(1, 2'd2, 0, 32'h100,  32'hDEADBEEF, 2, 32'h00000000, 0, 0, 12'h040, 32'hDEADBEEF);
      tbl[1]  = mk(0, 2'd2, 0, 32'h100,  32'h0,        2, 32'hDEADBEEF, 0, 0, 12'h040, 32'hDEADBEEF);
      tbl[2]  = mk(1, 2'd2, 0, 32'h100,  32'h11223344, 2, 32'hDEADBEEF, 0, 0, 12'h040, 32'h11223344);
      tbl[3]  = mk(1, 2'd0, 0, 32'h101,  32'h123456AA, 3, 32'hDEADBEEF, 0, 0, 12'h040, 32'h1122AA44);
      tbl[4]  = mk(0, 2'd0, 0, 32'h101,  32'h0,        2, 32'hFFFFFFAA, 0, 0, 12'h040, 32'h1122AA44);
      tbl[5]  = mk(0, 2'd0, 1, 32'h101,  32'h0,        2, 32'h000000AA, 0, 0, 12'h040, 32'h1122AA44);
      tbl[6]  = mk(1, 2'd1, 0, 32'h102,  32'hFFFF8001, 3, 32'h000000AA, 0, 0, 12'h040, 32'h8001AA44);
      tbl[7]  = mk(0, 2'd1, 0, 32'h102,  32'h0,        2, 32'hFFFF8001, 0, 0, 12'h040, 32'h8001AA44);
      tbl[8]  = mk(0, 2'd1, 1, 32'h102,  32'h0,        2, 32'h00008001, 0, 0, 12'h040, 32'h8001AA44);
      tbl[9]  = mk(0, 2'd2, 0, 32'h103,  32'h0,        1, 32'h00008001, 1, 0, 12'h040, 32'h8001AA44);
      tbl[10] = mk(1, 2'd1, 0, 32'h101,  32'h5555,     1, 32'h00008001, 1, 0, 12'h040, 32'h8001AA44);
      tbl[11] = mk(1, 2'd2, 0, 32'h4000, 32'hCAFEF00D, 1, 32'h00008001, 0, 1, 12'h000, 32'h00000000);
      tbl[12] = mk(0, 2'd0, 0, 32'h100,  32'h0,        2, 32'h00000044, 0, 0, 12'h040, 32'h8001AA44);
      tbl[13] = mk(0, 2'd1, 0, 32'h100,  32'h0,        2, 32'hFFFFAA44, 0, 0, 12'h040, 32'h8001AA44);
      tbl[14] = mk(1, 2'd0, 0, 32'h103,  32'h0000007F, 3, 32'hFFFFAA44, 0, 0, 12'h040, 32'h7F01AA44);
      tbl[15] = mk(0, 2'd0, 0, 32'h103,  32'h0,        2, 32'h0000007F, 0, 0, 12'h040, 32'h7F01AA44);
      tbl[16] = mk(0, 2'd3, 0, 32'h100,  32'h0,        1, 32'h0000007F, 1, 0, 12'h040, 32'h7F01AA44);
      tbl[17] = mk(1, 2'd1, 0, 32'h100,  32'h1234BEEF, 3, 32'h0000007F, 0, 0, 12'h040, 32'h7F01BEEF);
      tbl[18] = mk(0, 2'd2, 0, 32'h100,  32'h0,        2, 32'h7F01BEEF, 0, 0, 12'h040, 32'h7F01BEEF);
      tbl[19] = mk(1, 2'd2, 0, 32'h3FFC, 32'h5A5A5A5A, 2, 32'h7F01BEEF, 0, 0, 12'hFFF, 32'h5A5A5A5A);
      tbl[20] = mk(0, 2'd2, 0, 32'h3FFC, 32'h0,        2, 32'h5A5A5A5A, 0, 0, 12'hFFF, 32'h5A5A5A5A);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {31'd0, busy_o}, 32'd0);
      chk("reset done", {31'd0, done_o}, 32'd0);
      chk("reset rdata", rdata_o, 32'd0);
      chk("reset flags", {30'd0, misaligned_o, oob_o}, 32'd0);
      chk("reset wr_en", {31'd0, ram_wr_en_o}, 32'd0);
      chk("reset ram_addr", ram_addr_o, 32'd0);
      chk("reset ram_data", ram_data_o, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 21; i++) run_vec(i, tbl[i]);

      // Back-to-back loads with req_i held: accepts land on every third edge.
      exp_rd[0] = 32'h7F01BEEF; exp_rd[1] = 32'h000000BE;
      exp_rd[2] = 32'h7F01BEEF; exp_rd[3] = 32'h000000BE;
      done_cnt = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (done_o) begin
            if (done_cnt < 4) chk($sformatf("hold rdata%0d", done_cnt), rdata_o, exp_rd[done_cnt]);
            $display("hold done %0d rdata=%08h", done_cnt, rdata_o);
            done_cnt++;
         end
         if (ram_wr_en_o) chk("hold wr_en", 32'd1, 32'd0);
         req_i = (k < 12);
         we_i = 1'b0;
         size_i = (k % 2 == 0) ? 2'd2 : 2'd0;
         unsigned_i = 1'b1;
         addr_i = (k % 2 == 0) ? 32'h100 : 32'h101;
      end
      chk("hold done count", 32'(done_cnt), 32'd4);

      // Reset asserted while a byte store sits in ACCESS.
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b1; size_i = 2'd0; addr_i = 32'h100; wdata_i = 32'h55;
      @(negedge clk);
      req_i = 1'b0;
      chk("rst_mid busy_before", {31'd0, busy_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid busy_after", {31'd0, busy_o}, 32'd0);
      chk("rst_mid done", {31'd0, done_o}, 32'd0);
      chk("rst_mid wr_en", {31'd0, ram_wr_en_o}, 32'd0);
      done_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done_o || ram_wr_en_o) done_cnt++;
      end
      chk("rst_mid late_pulses", 32'(done_cnt), 32'd0);
      chk("rst_mid word", mem[12'h040], 32'h7F01BEEF);
      chk("rst_mid rdata", rdata_o, 32'd0);
      $display("reset mid-op busy=%0d word=%08h", busy_o, mem[12'h040]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
